// File: rtl/stream_fifo_flushable.sv
// Ready/valid stream FIFO with synchronous flush and power-of-two depth.
// Define STREAM_FIFO_FALL_THROUGH_EN to present an incoming beat on the output while empty.
module stream_fifo_flushable #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [DATA_WIDTH-1:0]  data_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic [$clog2(DEPTH):0] usage_o
);

  localparam int unsigned ADDR_W  = $clog2(DEPTH);
  localparam int unsigned USAGE_W = ADDR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [USAGE_W-1:0]    usage_q, usage_d;
  logic                  empty, full;
  logic                  push, pop;
  logic                  store, drain;

  // Handshake decode and next-state computation.
  always_comb begin
    empty    = (usage_q == '0);
    full     = (usage_q == USAGE_W'(DEPTH));
    ready_o  = !full && !flush_i;
    valid_o  = !empty && !flush_i;
    data_o   = mem_q[rd_ptr_q];
`ifdef STREAM_FIFO_FALL_THROUGH_EN
    if (empty && valid_i && !flush_i) begin
      valid_o = 1'b1;
      data_o  = data_i;
    end
`endif
    push  = valid_i && ready_o && !flush_i;
    pop   = valid_o && ready_i && !flush_i;
    store = push;
    drain = pop;
`ifdef STREAM_FIFO_FALL_THROUGH_EN
    // An empty FIFO hands the beat straight through without touching storage.
    if (empty && push && pop) begin
      store = 1'b0;
      drain = 1'b0;
    end
`endif
    wr_ptr_d = store ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = drain ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    unique case ({store, drain})
      2'b10:   usage_d = usage_q + USAGE_W'(1);
      2'b01:   usage_d = usage_q - USAGE_W'(1);
      default: usage_d = usage_q;
    endcase
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usage_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
    end
  end

  // Storage is deliberately left unreset; data_o is qualified by valid_o.
  always_ff @(posedge clk_i) begin
    if (store && !rst_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign usage_o = usage_q;

endmodule
